// File: rtl/cla_nibble_seq.sv
// cla_nibble_seq
//   Multi-cycle adder/subtractor. A single 4-bit carry look-ahead slice is
//   reused over a W = 4*NIBBLES bit operand, one nibble per clock, least
//   significant nibble first. The slice carry-out is registered between passes.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   requester presents an operation
//   in_ready   block can accept an operation (IDLE and not in reset)
//   a, b       W-bit operands
//   cin        carry-in (add) / borrow-in (sub)
//   sub        0: a+b+cin, 1: a-b-cin
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts result
//   sum        W-bit result
//   cout       carry-out of MSB nibble (sub: 1 = no borrow)
//   ovf        signed overflow (carry into MSB xor carry out of MSB)

module cla_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 ovf
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    a_reg, b_reg, sum_reg;
  logic            carry_reg, cout_reg, ovf_reg;
  logic [IDXW-1:0] idx_reg;

  // CLA slice signals
  logic [3:0] a_nib, b_nib, p, g, slice_sum;
  logic [4:0] c;
  logic       last_pass;

  assign last_pass = (idx_reg == LAST_IDX);

  // Nibble select for the current pass.
  always_comb begin
    a_nib = 4'd0;
    b_nib = 4'd0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_reg == IDXW'(i)) begin
        a_nib = a_reg[4*i +: 4];
        b_nib = b_reg[4*i +: 4];
      end
    end
  end

  // P/G generation and sum block, one bit per lane.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign p[gi]         = a_nib[gi] ^ b_nib[gi];
      assign g[gi]         = a_nib[gi] & b_nib[gi];
      assign slice_sum[gi] = p[gi] ^ c[gi];
    end
  endgenerate

  // Carry look-ahead block: every carry is a flat function of P, G and c0.
  assign c[0] = carry_reg;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_pass) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath. Subtraction is a + ~b + ~cin, so the inversion is folded in
  // once at accept time and the slice only ever adds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      idx_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            carry_reg <= cin ^ sub;
            idx_reg   <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx_reg == IDXW'(i)) begin
              sum_reg[4*i +: 4] <= slice_sum;
            end
          end
          carry_reg <= c[4];
          idx_reg   <= idx_reg + 1'b1;
          // On the MSB pass c3 is the carry into the MSB, so the overflow
          // flag is taken directly from the live slice rather than a copy.
          if (last_pass) begin
            cout_reg <= c[4];
            ovf_reg  <= c[3] ^ c[4];
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE) && !rst;
  assign out_valid = (state_reg == DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign ovf       = ovf_reg;

endmodule
